spi_master: RTL and testbench

//  Byte-oriented SPI master (mode 0, MSB first); the initiator counterpart of the ICD spi_slave.

---
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, with chip-select held across
// back-to-back bytes while cs_hold_i is high.
module spi_master #(
    parameter int unsigned CLKDIV   = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       cs_hold_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_csn_o
);

    localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CSC_W  = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        ACTIVE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_cnt_nxt;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_cnt_nxt;
    logic [CSC_W-1:0]   cs_cnt;
    logic [CSC_W-1:0]   cs_cnt_nxt;
    logic [7:0]         tx_shift;
    logic [7:0]         tx_shift_nxt;
    logic [7:0]         rx_shift;
    logic [7:0]         rx_shift_nxt;
    logic [7:0]         rx_byte_nxt;
    logic               rx_valid_nxt;
    logic               sck_nxt;
    logic               csn_nxt;
    logic               ready_nxt;
    logic               busy_nxt;

    logic               handshake;
    logic               div_last;
    logic               sck_rise;
    logic               sck_fall;
    logic               byte_done;
    logic               setup_done;
    logic               hold_done;

    // Transfer events decoded from the current registered state
    assign handshake  = tx_valid_i & tx_ready_o;
    assign div_last   = (div_cnt == DIV_W'(CLKDIV - 1));
    assign sck_rise   = (state == SHIFT) & div_last & ~spi_sck_o;
    assign sck_fall   = (state == SHIFT) & div_last & spi_sck_o;
    assign byte_done  = sck_fall & (bit_cnt == 3'd7);
    assign setup_done = (cs_cnt == CSC_W'(CS_SETUP - 1));
    assign hold_done  = (cs_cnt == CSC_W'(CS_HOLD - 1));

    // MOSI is the MSB of the transmit shift register, itself a flop
    assign spi_mosi_o = tx_shift[7];

    // State register
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a handshake in ACTIVE takes priority over dropping CS
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = SETUP;
            SETUP:   if (setup_done) state_nxt = SHIFT;
            SHIFT:   if (byte_done) state_nxt = ACTIVE;
            ACTIVE: begin
                if (handshake) begin
                    state_nxt = SHIFT;
                end else if (!cs_hold_i) begin
                    state_nxt = HOLD;
                end
            end
            HOLD:    if (hold_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of counters, shift registers and registered outputs
    always_comb begin
        cs_cnt_nxt   = '0;
        div_cnt_nxt  = '0;
        bit_cnt_nxt  = '0;
        sck_nxt      = 1'b0;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_byte_nxt  = rx_byte_o;
        rx_valid_nxt = 1'b0;
        csn_nxt      = (state_nxt == IDLE);
        ready_nxt    = (state_nxt == IDLE) || (state_nxt == ACTIVE);
        busy_nxt     = (state_nxt != IDLE);

        if ((state_nxt == state) && ((state == SETUP) || (state == HOLD))) begin
            cs_cnt_nxt = cs_cnt + CSC_W'(1);
        end

        if ((state == SHIFT) && (state_nxt == SHIFT)) begin
            div_cnt_nxt = div_last ? '0 : div_cnt + DIV_W'(1);
            sck_nxt     = div_last ? ~spi_sck_o : spi_sck_o;
            bit_cnt_nxt = sck_fall ? bit_cnt + 3'd1 : bit_cnt;
        end

        if (sck_rise) begin
            rx_shift_nxt = {rx_shift[6:0], spi_miso_i};
        end

        if (handshake) begin
            tx_shift_nxt = tx_byte_i;
        end else if (sck_fall && !byte_done) begin
            tx_shift_nxt = {tx_shift[6:0], 1'b0};
        end

        if (byte_done) begin
            rx_valid_nxt = 1'b1;
            rx_byte_nxt  = rx_shift;
        end
    end

    // Datapath and output registers; reset discards any partial byte
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            cs_cnt     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_byte_o  <= '0;
            rx_valid_o <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_csn_o  <= 1'b1;
            tx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            cs_cnt     <= cs_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_shift   <= tx_shift_nxt;
            rx_shift   <= rx_shift_nxt;
            rx_byte_o  <= rx_byte_nxt;
            rx_valid_o <= rx_valid_nxt;
            spi_sck_o  <= sck_nxt;
            spi_csn_o  <= csn_nxt;
            tx_ready_o <= ready_nxt;
            busy_o     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a mode-0 flash model and
// scoreboards for MOSI bytes and received bytes.
module tb_spi_master;

    logic       clk6x = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       cs_hold = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso = 1'b0;
    logic       spi_csn;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sck_rises = 0;
    int csn_rises = 0;
    int rx_pulses = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] flash_q[$];

    spi_master #(.CLKDIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk6x      (clk6x),
        .resetn     (resetn),
        .tx_byte_i  (tx_byte),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .cs_hold_i  (cs_hold),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .busy_o     (busy),
        .spi_sck_o  (spi_sck),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso),
        .spi_csn_o  (spi_csn)
    );

    always #5 clk6x = ~clk6x;

    always @(posedge clk6x) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash model: next response byte loaded at CS fall and after every 8th SCK fall
    int         fl_bit = 0;
    bit         fl_active = 1'b0;
    logic [7:0] fl_sr = 8'h00;
    always @(negedge spi_sck or negedge spi_csn or posedge spi_csn) begin
        if (spi_csn) begin
            fl_bit    = 0;
            fl_active = 1'b0;
        end else if (!fl_active) begin
            fl_active = 1'b1;
            fl_bit    = 0;
            fl_sr     = (flash_q.size() > 0) ? flash_q.pop_front() : 8'h00;
        end else begin
            fl_bit++;
            if (fl_bit == 8) begin
                fl_bit = 0;
                fl_sr  = (flash_q.size() > 0) ? flash_q.pop_front() : 8'h00;
            end else begin
                fl_sr = {fl_sr[6:0], 1'b0};
            end
        end
        spi_miso = fl_sr[7];
    end

    // MOSI capture at SCK rises; partial bytes are dropped when CS rises
    int         m_bits = 0;
    logic [7:0] m_sr = 8'h00;
    always @(posedge spi_sck or posedge spi_csn) begin
        if (spi_csn) begin
            m_bits = 0;
        end else begin
            sck_rises++;
            m_sr = {m_sr[6:0], spi_mosi};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (exp_mosi.size() == 0) check("mosi_unexpected", 32'(1), 32'(0));
                else check("mosi_byte", 32'(m_sr), 32'(exp_mosi.pop_front()));
            end
        end
    end

    always @(posedge spi_csn) csn_rises++;

    // Received-byte scoreboard
    always @(negedge clk6x) begin
        if (rx_valid) begin
            rx_pulses++;
            if (exp_rx.size() == 0) check("rx_unexpected", 32'(1), 32'(0));
            else check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
        end
    end

    // Offer a byte (called at a negedge); returns the handshake cycle
    task automatic send(input logic [7:0] b, input logic [7:0] resp, input bit hold, output int t0);
        bit ok;
        ok = 1'b0;
        t0 = -1;
        tx_byte  = b;
        tx_valid = 1'b1;
        cs_hold  = hold;
        exp_mosi.push_back(b);
        exp_rx.push_back(resp);
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk6x);
        end
        if (!ok) check("handshake_timeout", 32'(0), 32'(1));
        t0 = cyc;
        @(negedge clk6x);
        tx_valid = 1'b0;
        tx_byte  = 8'($urandom);
    endtask

    task automatic wait_rx(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk6x);
            if (rx_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("rx_timeout", 32'(0), 32'(1));
    endtask

    // CS must stay low for the two HOLD cycles after the deciding ACTIVE cycle
    task automatic check_hold(input string tag);
        @(negedge clk6x);
        check({tag, "_hold1_csn"}, 32'(spi_csn), 32'(0));
        @(negedge clk6x);
        check({tag, "_hold2_csn"}, 32'(spi_csn), 32'(0));
        @(negedge clk6x);
        check({tag, "_idle_csn"}, 32'(spi_csn), 32'(1));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
        @(negedge clk6x);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, ta, tb, base, cbase, bad, rbase;

        repeat (3) @(negedge clk6x);
        check("rst_csn", 32'(spi_csn), 32'(1));
        check("rst_sck", 32'(spi_sck), 32'(0));
        check("rst_mosi", 32'(spi_mosi), 32'(0));
        check("rst_rx_byte", 32'(rx_byte), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_ready", 32'(tx_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk6x);

        // Single byte from IDLE
        flash_q.push_back(8'h3C);
        send(8'hA5, 8'h3C, 1'b0, t0);
        check("t1_setup_csn", 32'(spi_csn), 32'(0));
        check("t1_setup_mosi", 32'(spi_mosi), 32'(1));
        check("t1_setup_ready", 32'(tx_ready), 32'(0));
        check("t1_setup_busy", 32'(busy), 32'(1));
        wait_rx(ta);
        check("t1_latency", 32'(ta - t0), 32'(35));
        check_hold("t1");

        // Two bytes back to back with CS held
        flash_q.push_back(8'h5A);
        flash_q.push_back(8'hC3);
        base  = sck_rises;
        cbase = csn_rises;
        send(8'h9F, 8'h5A, 1'b1, t0);
        wait_rx(ta);
        send(8'h00, 8'hC3, 1'b1, t0);
        wait_rx(tb);
        check("t2_rx_spacing", 32'(tb - ta), 32'(33));
        check("t2_sck_rises", 32'(sck_rises - base), 32'(16));
        check("t2_csn_rises", 32'(csn_rises - cbase), 32'(0));
        cs_hold = 1'b0;
        check_hold("t2");

        // Idle in ACTIVE, then drop cs_hold
        flash_q.push_back(8'h11);
        send(8'h42, 8'h11, 1'b1, t0);
        wait_rx(ta);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk6x);
            if (spi_csn !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("t3_active_wait", 32'(bad), 32'(0));
        cs_hold = 1'b0;
        check_hold("t3");

        // Request held during SHIFT is not taken until ACTIVE
        flash_q.push_back(8'h77);
        flash_q.push_back(8'h66);
        send(8'h81, 8'h77, 1'b1, t0);
        tx_byte  = 8'hFF;
        tx_valid = 1'b1;
        exp_mosi.push_back(8'hFF);
        exp_rx.push_back(8'h66);
        bad = 0;
        ta  = -1;
        for (int i = 0; i < 200; i++) begin
            if (rx_valid) begin
                ta = cyc;
                break;
            end
            if (tx_ready) bad++;
            @(negedge clk6x);
        end
        check("t4_ready_low", 32'(bad), 32'(0));
        check("t4_rx_seen", 32'(ta >= 0), 32'(1));
        check("t4_ready_active", 32'(tx_ready), 32'(1));
        @(negedge clk6x);
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        cs_hold  = 1'b0;
        wait_rx(tb);
        check("t4_latency", 32'(tb - ta), 32'(33));
        check_hold("t4");

        // Asynchronous reset mid-byte
        flash_q.push_back(8'hAA);
        base = sck_rises;
        send(8'hC6, 8'hAA, 1'b0, t0);
        for (int i = 0; i < 200; i++) begin
            if (sck_rises - base >= 3) break;
            @(negedge clk6x);
        end
        check("t5_three_rises", 32'(sck_rises - base), 32'(3));
        #1 resetn = 1'b0;
        #1;
        check("t5_rst_csn", 32'(spi_csn), 32'(1));
        check("t5_rst_sck", 32'(spi_sck), 32'(0));
        check("t5_rst_mosi", 32'(spi_mosi), 32'(0));
        check("t5_rst_ready", 32'(tx_ready), 32'(1));
        check("t5_rst_busy", 32'(busy), 32'(0));
        exp_rx.delete();
        exp_mosi.delete();
        flash_q.delete();
        rbase = rx_pulses;
        repeat (2) @(negedge clk6x);
        resetn = 1'b1;
        repeat (40) @(negedge clk6x);
        check("t5_no_rx_valid", 32'(rx_pulses - rbase), 32'(0));
        flash_q.push_back(8'h0F);
        send(8'h3E, 8'h0F, 1'b0, t0);
        wait_rx(ta);
        check("t5_post_latency", 32'(ta - t0), 32'(35));
        check_hold("t5");

        // Handshake together with cs_hold low in ACTIVE
        flash_q.push_back(8'h21);
        flash_q.push_back(8'h43);
        cbase = csn_rises;
        send(8'h12, 8'h21, 1'b1, t0);
        wait_rx(ta);
        send(8'h34, 8'h43, 1'b0, t0);
        wait_rx(tb);
        check("t6_rx_spacing", 32'(tb - ta), 32'(33));
        check("t6_csn_rises", 32'(csn_rises - cbase), 32'(0));
        check_hold("t6");

        check("end_exp_rx_empty", 32'(exp_rx.size()), 32'(0));
        check("end_exp_mosi_empty", 32'(exp_mosi.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
